// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit memory bus between fetch and data access.
// MEM has priority, except that IF wins right after a MEM grant so fetch cannot starve.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        err_o,
    output logic [5:0]  stall_o
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        last_mem_q, last_mem_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ce_q, ce_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_data_q, if_data_d;
    logic        if_ack_q, if_ack_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_ack_q, mem_ack_d;
    logic        err_q, err_d;

    logic        if_ok, mem_ok, done;
    logic [7:0]  cnt_inc;
    logic [31:0] rdata;

    // Arbitration, wait counting and completion (ack or timeout abort)
    always_comb begin
        state_d     = state_q;
        last_mem_d  = last_mem_q;
        cnt_d       = cnt_q;
        ce_d        = ce_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_data_d   = if_data_q;
        if_ack_d    = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_ack_d   = 1'b0;
        err_d       = 1'b0;
        // A requester still holding req in its own ack cycle is not re-served.
        if_ok       = if_req_i & ~if_ack_q;
        mem_ok      = mem_req_i & ~mem_ack_q;
        cnt_inc     = cnt_q + 8'd1;
        done        = 1'b0;
        rdata       = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (mem_ok && !(last_mem_q && if_ok)) begin
                    state_d    = MEM_BUSY;
                    last_mem_d = 1'b1;
                    cnt_d      = 8'd0;
                    ce_d       = 1'b1;
                    we_d       = mem_we_i;
                    sel_d      = mem_sel_i;
                    addr_d     = mem_addr_i;
                    wdata_d    = mem_wdata_i;
                end else if (if_ok) begin
                    state_d    = IF_BUSY;
                    last_mem_d = 1'b0;
                    cnt_d      = 8'd0;
                    ce_d       = 1'b1;
                    we_d       = 1'b0;
                    sel_d      = 4'b1111;
                    addr_d     = if_addr_i;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                done  = bus_ack_i | (cnt_inc == TMO);
                rdata = bus_ack_i ? bus_rdata_i : 32'h0;
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    err_d   = ~bus_ack_i;
                    if (state_q == IF_BUSY) begin
                        if_ack_d  = 1'b1;
                        if_data_d = rdata;
                    end else begin
                        mem_ack_d   = 1'b1;
                        mem_rdata_d = rdata;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_mem_q  <= 1'b0;
            cnt_q       <= 8'd0;
            ce_q        <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            if_data_q   <= 32'h0;
            if_ack_q    <= 1'b0;
            mem_rdata_q <= 32'h0;
            mem_ack_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_mem_q  <= last_mem_d;
            cnt_q       <= cnt_d;
            ce_q        <= ce_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_data_q   <= if_data_d;
            if_ack_q    <= if_ack_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ack_q   <= mem_ack_d;
            err_q       <= err_d;
        end
    end

    // Stall vector: a pending data access freezes pc..mem, a pending fetch pc..if
    always_comb begin
        stall_o = 6'b000000;
        if (!rst) begin
            stall_o = 6'b000000;
        end else if (mem_req_i && !mem_ack_q) begin
            stall_o = 6'b011111;
        end else if (if_req_i && !if_ack_q) begin
            stall_o = 6'b000011;
        end
    end

    assign if_data_o   = if_data_q;
    assign if_ack_o    = if_ack_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ack_o   = mem_ack_q;
    assign bus_ce_o    = ce_q;
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign err_o       = err_q;

endmodule
